// File: rtl/midi_preset_ctrl_pkg.sv
// Shared types and helpers for the MIDI preset engine: FSM states, message
// status constants, flash word field layout and message word helpers.
package midi_pkg;

    typedef enum logic [2:0] {
        LOAD_REQ,
        LOAD_WAIT,
        IDLE,
        STORE_REQ,
        STORE_WAIT
    } preset_state_t;

    localparam logic [7:0] CC_MSG = 8'hB0;
    localparam logic [7:0] PC_MSG = 8'hC0;

    // Flash word layout: status | data1 | data2 | bits_cnt
    localparam int STATUS_LSB = 24;
    localparam int DATA1_LSB  = 16;
    localparam int DATA2_LSB  = 8;
    localparam int BITS_LSB   = 0;

    // A stored word is usable only if it carries a status byte and a legal bit count
    function automatic logic msg_valid(input logic [31:0] word);
        logic [7:0] status;
        logic [7:0] bits;
        status = word[STATUS_LSB +: 8];
        bits   = word[BITS_LSB +: 8];
        return status[7] && (bits == 8'd10 || bits == 8'd20 || bits == 8'd30);
    endfunction

    // Serial bit count for a message of 1..3 bytes (10 bits per UART frame)
    function automatic logic [7:0] msg_bits(input logic [1:0] bytes);
        return {6'd0, bytes} * 8'd10;
    endfunction

endpackage

// File: rtl/midi_preset_ctrl_ram.sv
// Slot storage: DEPTH words of 32 bits, one write port and two
// combinational read ports (one for playback, one for flash write-back).
module preset_ram #(
    parameter int DEPTH = 4,
    parameter int AW    = 4
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] wr_idx,
    input  logic [31:0]   wr_data,
    input  logic [AW-1:0] play_idx,
    output logic [31:0]   play_data,
    input  logic [AW-1:0] store_idx,
    output logic [31:0]   store_data
);

    localparam int            IW   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [AW-1:0] LAST = AW'(DEPTH - 1);

    logic [31:0] mem [DEPTH];

    // Single write port; out-of-range indices are dropped
    always_ff @(posedge clk) begin
        if (we && wr_idx <= LAST) begin
            mem[wr_idx[IW-1:0]] <= wr_data;
        end
    end

    assign play_data  = (play_idx  <= LAST) ? mem[play_idx[IW-1:0]]  : '0;
    assign store_data = (store_idx <= LAST) ? mem[store_idx[IW-1:0]] : '0;

endmodule

// File: rtl/midi_preset_ctrl.sv
// Preset engine for the MIDI pedal: loads one message word per footswitch
// from flash after reset, plays a slot to midi_out on a press, and in save
// mode learns the last received message into a slot and writes it back.
module midi_preset_ctrl
    import midi_pkg::*;
#(
    parameter int          BUTTONS_CNT = 4,
    parameter int          BTN_W       = 4,
    parameter int          MIDI_CH     = 0,
    parameter int          FIRST_CC    = 46,
    parameter int          CC_VALUE    = 127,
    parameter logic [23:0] BASE_ADDR   = 24'h1ffd80,
    parameter int          MAX_RETRY   = 3
) (
    input  logic                   clk,
    input  logic                   rst_i,
    input  logic [BTN_W-1:0]       btn_index,
    input  logic                   save_mode,
    input  logic                   learn_valid,
    input  logic [7:0]             learn_status,
    input  logic [7:0]             learn_data1,
    input  logic [7:0]             learn_data2,
    input  logic [1:0]             learn_bytes,
    output logic [23:0]            fl_adr_o,
    output logic [31:0]            fl_dat_o,
    output logic                   fl_we_o,
    output logic                   fl_stb_o,
    input  logic [31:0]            fl_dat_i,
    input  logic                   fl_ack_i,
    input  logic                   fl_rty_i,
    output logic [7:0]             out_status,
    output logic [7:0]             out_data1,
    output logic [7:0]             out_data2,
    output logic [7:0]             out_bits_cnt,
    output logic                   out_trigger,
    input  logic                   out_busy,
    output logic                   loaded,
    output logic                   busy,
    output logic [BUTTONS_CNT-1:0] slot_init
);

    localparam logic [BTN_W-1:0] ONE       = BTN_W'(1);
    localparam logic [BTN_W-1:0] LAST_SLOT = BTN_W'(BUTTONS_CNT);
    localparam logic [7:0]       MAX_RTY   = 8'(MAX_RETRY);

    preset_state_t    state;
    logic [BTN_W-1:0] idx;
    logic [7:0]       retry;
    logic             learned_vld;
    logic [31:0]      learn_word;
    logic [BTN_W-1:0] store_idx;
    logic             pend_vld;
    logic [BTN_W-1:0] pend_idx;

    logic             ram_we;
    logic [BTN_W-1:0] ram_wr_idx;
    logic [31:0]      ram_wr_data;
    logic [31:0]      ram_play_data;
    logic [31:0]      ram_store_data;
    logic [31:0]      play_word;

    logic btn_ok;
    logic store_press;
    logic play_press;
    logic rty_done;

    // One-hot slot_init bit for slot k (1-based); slot 0 means none
    function automatic logic [BUTTONS_CNT-1:0] slot_mask(input logic [BTN_W-1:0] k);
        if (k == '0) begin
            return '0;
        end
        return BUTTONS_CNT'(1) << (k - ONE);
    endfunction

    // Flash byte address of slot k (1-based), four bytes per slot
    function automatic logic [23:0] slot_addr(input logic [BTN_W-1:0] k);
        return BASE_ADDR + (24'(k - ONE) << 2);
    endfunction

    // Fallback CC message for a slot without a valid stored word
    function automatic logic [31:0] default_word(input logic [BTN_W-1:0] k);
        return {CC_MSG | 8'(MIDI_CH), 8'(FIRST_CC - 1) + 8'(k), 8'(CC_VALUE), 8'd30};
    endfunction

    assign btn_ok      = (btn_index != '0) && (btn_index <= LAST_SLOT);
    assign store_press = (state == IDLE) && btn_ok && save_mode && learned_vld;
    assign play_press  = loaded && btn_ok && !save_mode;
    assign rty_done    = (retry + 8'd1) == MAX_RTY;
    assign busy        = (state != IDLE);

    assign play_word = (|(slot_init & slot_mask(pend_idx))) ? ram_play_data
                                                            : default_word(pend_idx);

    // Slot write port: flash read data during load, learned word on a save press
    always_comb begin
        ram_we      = 1'b0;
        ram_wr_idx  = '0;
        ram_wr_data = '0;
        if (state == LOAD_WAIT && fl_ack_i) begin
            ram_we      = 1'b1;
            ram_wr_idx  = idx - ONE;
            ram_wr_data = fl_dat_i;
        end else if (store_press) begin
            ram_we      = 1'b1;
            ram_wr_idx  = btn_index - ONE;
            ram_wr_data = learn_word;
        end
    end

    preset_ram #(
        .DEPTH (BUTTONS_CNT),
        .AW    (BTN_W)
    ) u_ram (
        .clk        (clk),
        .we         (ram_we),
        .wr_idx     (ram_wr_idx),
        .wr_data    (ram_wr_data),
        .play_idx   (pend_idx - ONE),
        .play_data  (ram_play_data),
        .store_idx  (store_idx - ONE),
        .store_data (ram_store_data)
    );

    // Flash load/store sequencer plus the learned-message latch
    always_ff @(posedge clk) begin
        if (rst_i) begin
            state       <= LOAD_REQ;
            idx         <= ONE;
            retry       <= '0;
            slot_init   <= '0;
            learned_vld <= 1'b0;
            store_idx   <= '0;
            loaded      <= 1'b0;
            fl_adr_o    <= '0;
            fl_dat_o    <= '0;
            fl_we_o     <= 1'b0;
            fl_stb_o    <= 1'b0;
        end else begin
            case (state)
                LOAD_REQ: begin
                    fl_stb_o <= 1'b1;
                    fl_we_o  <= 1'b0;
                    fl_adr_o <= slot_addr(idx);
                    state    <= LOAD_WAIT;
                end
                LOAD_WAIT: begin
                    if (fl_ack_i || (fl_rty_i && rty_done)) begin
                        fl_stb_o <= 1'b0;
                        retry    <= '0;
                        idx      <= idx + ONE;
                        if (fl_ack_i) begin
                            slot_init <= (slot_init & ~slot_mask(idx))
                                       | (msg_valid(fl_dat_i) ? slot_mask(idx) : '0);
                        end else begin
                            slot_init <= slot_init & ~slot_mask(idx);
                        end
                        if (idx == LAST_SLOT) begin
                            state  <= IDLE;
                            loaded <= 1'b1;
                        end else begin
                            state <= LOAD_REQ;
                        end
                    end else if (fl_rty_i) begin
                        fl_stb_o <= 1'b0;
                        retry    <= retry + 8'd1;
                        state    <= LOAD_REQ;
                    end
                end
                IDLE: begin
                    if (store_press) begin
                        slot_init   <= slot_init | slot_mask(btn_index);
                        learned_vld <= 1'b0;
                        store_idx   <= btn_index;
                        state       <= STORE_REQ;
                    end
                end
                STORE_REQ: begin
                    fl_stb_o <= 1'b1;
                    fl_we_o  <= 1'b1;
                    fl_adr_o <= slot_addr(store_idx);
                    fl_dat_o <= ram_store_data;
                    state    <= STORE_WAIT;
                end
                STORE_WAIT: begin
                    if (fl_ack_i || (fl_rty_i && rty_done)) begin
                        fl_stb_o <= 1'b0;
                        fl_we_o  <= 1'b0;
                        retry    <= '0;
                        state    <= IDLE;
                    end else if (fl_rty_i) begin
                        fl_stb_o <= 1'b0;
                        retry    <= retry + 8'd1;
                        state    <= STORE_REQ;
                    end
                end
                default: begin
                    state <= LOAD_REQ;
                end
            endcase
            // A message arriving in the same cycle as a save press stays latched
            if (learn_valid) begin
                learned_vld <= 1'b1;
            end
        end
    end

    // Learned message word, kept ready in flash layout
    always_ff @(posedge clk) begin
        if (learn_valid) begin
            learn_word <= {learn_status, learn_data1, learn_data2, msg_bits(learn_bytes)};
        end
    end

    // Keep the latest play press pending and hand it to midi_out when it is free
    always_ff @(posedge clk) begin
        if (rst_i) begin
            pend_vld     <= 1'b0;
            pend_idx     <= '0;
            out_status   <= '0;
            out_data1    <= '0;
            out_data2    <= '0;
            out_bits_cnt <= '0;
            out_trigger  <= 1'b0;
        end else begin
            out_trigger <= 1'b0;
            if (pend_vld && !out_busy && !out_trigger) begin
                out_trigger  <= 1'b1;
                out_status   <= play_word[STATUS_LSB +: 8];
                out_data1    <= play_word[DATA1_LSB +: 8];
                out_data2    <= play_word[DATA2_LSB +: 8];
                out_bits_cnt <= play_word[BITS_LSB +: 8];
                pend_vld     <= 1'b0;
            end
            if (play_press) begin
                pend_vld <= 1'b1;
                pend_idx <= btn_index;
            end
        end
    end

endmodule

// File: tb/tb_midi_preset_ctrl.sv
// Directed bench for midi_preset_ctrl: flash load with retries and reset,
// default and stored playback, learn/store, busy handling, ignored presses.
module tb_midi_preset_ctrl;

    logic        clk = 1'b0;
    logic        rst_i;
    logic [3:0]  btn_index;
    logic        save_mode;
    logic        learn_valid;
    logic [7:0]  learn_status;
    logic [7:0]  learn_data1;
    logic [7:0]  learn_data2;
    logic [1:0]  learn_bytes;
    logic [23:0] fl_adr_o;
    logic [31:0] fl_dat_o;
    logic        fl_we_o;
    logic        fl_stb_o;
    logic [31:0] fl_dat_i;
    logic        fl_ack_i;
    logic        fl_rty_i;
    logic [7:0]  out_status;
    logic [7:0]  out_data1;
    logic [7:0]  out_data2;
    logic [7:0]  out_bits_cnt;
    logic        out_trigger;
    logic        out_busy;
    logic        loaded;
    logic        busy;
    logic [3:0]  slot_init;

    int n_chk  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    midi_preset_ctrl dut (
        .clk          (clk),
        .rst_i        (rst_i),
        .btn_index    (btn_index),
        .save_mode    (save_mode),
        .learn_valid  (learn_valid),
        .learn_status (learn_status),
        .learn_data1  (learn_data1),
        .learn_data2  (learn_data2),
        .learn_bytes  (learn_bytes),
        .fl_adr_o     (fl_adr_o),
        .fl_dat_o     (fl_dat_o),
        .fl_we_o      (fl_we_o),
        .fl_stb_o     (fl_stb_o),
        .fl_dat_i     (fl_dat_i),
        .fl_ack_i     (fl_ack_i),
        .fl_rty_i     (fl_rty_i),
        .out_status   (out_status),
        .out_data1    (out_data1),
        .out_data2    (out_data2),
        .out_bits_cnt (out_bits_cnt),
        .out_trigger  (out_trigger),
        .out_busy     (out_busy),
        .loaded       (loaded),
        .busy         (busy),
        .slot_init    (slot_init)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Wait (bounded) for a flash request and check its address/direction/data
    task automatic wait_req(input string tag, input logic [23:0] adr, input logic we,
                            input logic [31:0] dat, input bit chk_dat);
        int n = 0;
        while (!fl_stb_o && n < 20) begin
            @(negedge clk);
            n++;
        end
        check({tag, "_stb"}, fl_stb_o, 1'b1);
        check({tag, "_adr"}, fl_adr_o, adr);
        check({tag, "_we"}, fl_we_o, we);
        if (chk_dat) check({tag, "_dat"}, fl_dat_o, dat);
    endtask

    // Answer the pending request with ack (rty=0) or rty (rty=1) for one cycle
    task automatic respond(input string tag, input logic [31:0] d, input bit rty);
        fl_dat_i = d;
        if (rty) fl_rty_i = 1'b1;
        else     fl_ack_i = 1'b1;
        @(negedge clk);
        fl_ack_i = 1'b0;
        fl_rty_i = 1'b0;
        check({tag, "_drop"}, fl_stb_o, 1'b0);
    endtask

    // Play press with exact latency check: trigger one cycle after the press edge
    task automatic play(input string tag, input logic [3:0] k, input logic [7:0] st,
                        input logic [7:0] d1, input logic [7:0] d2, input logic [7:0] bc);
        btn_index = k;
        @(negedge clk);
        btn_index = 4'd0;
        check({tag, "_lat"}, out_trigger, 1'b0);
        @(negedge clk);
        check({tag, "_trig"}, out_trigger, 1'b1);
        check({tag, "_st"}, out_status, st);
        check({tag, "_d1"}, out_data1, d1);
        check({tag, "_d2"}, out_data2, d2);
        check({tag, "_bc"}, out_bits_cnt, bc);
        @(negedge clk);
        check({tag, "_pulse"}, out_trigger, 1'b0);
    endtask

    task automatic learn(input logic [7:0] st, input logic [7:0] d1, input logic [7:0] d2,
                         input logic [1:0] nb);
        learn_status = st;
        learn_data1  = d1;
        learn_data2  = d2;
        learn_bytes  = nb;
        learn_valid  = 1'b1;
        @(negedge clk);
        learn_valid  = 1'b0;
    endtask

    task automatic save_press(input logic [3:0] k);
        save_mode = 1'b1;
        btn_index = k;
        @(negedge clk);
        btn_index = 4'd0;
        save_mode = 1'b0;
    endtask

    // Count out_trigger pulses over n cycles
    task automatic count_trig(input int n, output int cnt);
        cnt = 0;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            if (out_trigger) cnt++;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int cnt;
        rst_i        = 1'b1;
        btn_index    = 4'd0;
        save_mode    = 1'b0;
        learn_valid  = 1'b0;
        learn_status = 8'd0;
        learn_data1  = 8'd0;
        learn_data2  = 8'd0;
        learn_bytes  = 2'd0;
        fl_dat_i     = 32'd0;
        fl_ack_i     = 1'b0;
        fl_rty_i     = 1'b0;
        out_busy     = 1'b0;
        repeat (2) @(negedge clk);

        // Reset state
        check("rst_stb", fl_stb_o, 1'b0);
        check("rst_adr", fl_adr_o, 24'h0);
        check("rst_dat", fl_dat_o, 32'h0);
        check("rst_trig", out_trigger, 1'b0);
        check("rst_status", out_status, 8'h0);
        check("rst_loaded", loaded, 1'b0);
        check("rst_init", slot_init, 4'b0000);
        rst_i = 1'b0;

        // Play press before load completes is dropped
        btn_index = 4'd1;
        @(negedge clk);
        btn_index = 4'd0;
        count_trig(3, cnt);
        check("preload_press", cnt, 0);

        // First slot, then reset while slot 2 is outstanding
        wait_req("ld0", 24'h1ffd80, 1'b0, 32'h0, 1'b0);
        respond("ld0", 32'hC0420014, 1'b0);
        wait_req("ld1", 24'h1ffd84, 1'b0, 32'h0, 1'b0);
        check("ld1_init", slot_init, 4'b0001);
        rst_i = 1'b1;
        @(negedge clk);
        rst_i = 1'b0;
        check("midrst_stb", fl_stb_o, 1'b0);
        check("midrst_adr", fl_adr_o, 24'h0);
        check("midrst_init", slot_init, 4'b0000);
        check("midrst_busy", busy, 1'b1);

        // Full reload: slot 2 refused three times, slots 3/4 invalid
        wait_req("rl0", 24'h1ffd80, 1'b0, 32'h0, 1'b0);
        respond("rl0", 32'hC0420014, 1'b0);
        for (int r = 0; r < 3; r++) begin
            wait_req("rl1", 24'h1ffd84, 1'b0, 32'h0, 1'b0);
            respond("rl1", 32'h0, 1'b1);
        end
        wait_req("rl2", 24'h1ffd88, 1'b0, 32'h0, 1'b0);
        respond("rl2", 32'hFFFFFFFF, 1'b0);
        wait_req("rl3", 24'h1ffd8c, 1'b0, 32'h0, 1'b0);
        check("rl3_notloaded", loaded, 1'b0);
        respond("rl3", 32'hFFFFFFFF, 1'b0);
        check("ld_loaded", loaded, 1'b1);
        check("ld_init", slot_init, 4'b0001);
        check("ld_busy", busy, 1'b0);

        // Default message for an uninitialised slot, then stored slot 1
        play("p3", 4'd3, 8'hB0, 8'h30, 8'h7F, 8'd30);
        play("p1", 4'd1, 8'hC0, 8'h42, 8'h00, 8'd20);

        // Learn and store into slot 2, then play it back
        learn(8'h90, 8'h3C, 8'h64, 2'd3);
        save_press(4'd2);
        wait_req("st2", 24'h1ffd84, 1'b1, 32'h903C641E, 1'b1);
        check("st2_busy", busy, 1'b1);
        respond("st2", 32'h0, 1'b0);
        check("st2_idle", busy, 1'b0);
        check("st2_init", slot_init, 4'b0011);
        play("p2", 4'd2, 8'h90, 8'h3C, 8'h64, 8'd30);

        // Save press with nothing learned is ignored
        save_press(4'd4);
        cnt = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (fl_stb_o) cnt++;
        end
        check("nolearn_stb", cnt, 0);
        check("nolearn_init", slot_init, 4'b0011);

        // Store that exhausts its retries keeps the learned word in the slot
        learn(8'hA0, 8'h11, 8'h22, 2'd2);
        save_press(4'd3);
        for (int r = 0; r < 3; r++) begin
            wait_req("st3", 24'h1ffd88, 1'b1, 32'hA0112214, 1'b1);
            respond("st3", 32'h0, 1'b1);
        end
        check("st3_idle", busy, 1'b0);
        check("st3_we", fl_we_o, 1'b0);
        check("st3_init", slot_init, 4'b0111);
        play("p3b", 4'd3, 8'hA0, 8'h11, 8'h22, 8'd20);

        // Presses while midi_out is busy: the newer one replaces the older
        out_busy  = 1'b1;
        btn_index = 4'd1;
        cnt = 0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            btn_index = (i == 20) ? 4'd4 : 4'd0;
            if (out_trigger) cnt++;
        end
        check("busy_hold", cnt, 0);
        out_busy = 1'b0;
        @(negedge clk);
        check("busy_trig", out_trigger, 1'b1);
        check("busy_st", out_status, 8'hB0);
        check("busy_d1", out_data1, 8'h31);
        check("busy_bc", out_bits_cnt, 8'd30);
        count_trig(10, cnt);
        check("busy_single", cnt, 0);

        // Out-of-range button is ignored
        btn_index = 4'd5;
        @(negedge clk);
        btn_index = 4'd0;
        count_trig(5, cnt);
        check("btn_range", cnt, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
